// File: rtl/ob_cntrl_mk_arb.sv
// ob_cntrl_mk_arb: market-order trade arbitration with a held valid/ready trade register
module ob_cntrl_mk_arb #(
   parameter int QTY_W    = 16,
   parameter int UID_W    = 32,
   parameter int PRICE_W  = 32,
   parameter int ARB_MODE = 0,
   parameter int MK_MK_EN = 1,
   parameter int CNT_W    = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               lm_bid_vld_r,
   input  logic [UID_W-1:0]   lm_bid_uid,
   input  logic [PRICE_W-1:0] lm_bid_price,
   input  logic [QTY_W-1:0]   lm_bid_qty,
   input  logic               lm_ask_vld_r,
   input  logic [UID_W-1:0]   lm_ask_uid,
   input  logic [PRICE_W-1:0] lm_ask_price,
   input  logic [QTY_W-1:0]   lm_ask_qty,
   input  logic               mk_bid_head_vld_r,
   input  logic [UID_W-1:0]   mk_bid_uid,
   input  logic [PRICE_W-1:0] mk_bid_price,
   input  logic [QTY_W-1:0]   mk_bid_qty,
   input  logic               mk_ask_head_vld_r,
   input  logic [UID_W-1:0]   mk_ask_uid,
   input  logic [PRICE_W-1:0] mk_ask_price,
   input  logic [QTY_W-1:0]   mk_ask_qty,
   input  logic               trade_qry,
   input  logic               trade_rdy,
   output logic               busy,
   output logic               trade_vld_r,
   output logic [2:0]         trade_kind_r,
   output logic [UID_W-1:0]   trade_ask_uid_r,
   output logic [UID_W-1:0]   trade_bid_uid_r,
   output logic [PRICE_W-1:0] trade_ask_price_r,
   output logic [PRICE_W-1:0] trade_bid_price_r,
   output logic               trade_ask_consumed_r,
   output logic               trade_bid_consumed_r,
   output logic [QTY_W-1:0]   trade_quantity_r,
   output logic [QTY_W-1:0]   trade_remainder_r,
   output logic [CNT_W-1:0]   trade_cnt_r
);
   typedef enum logic {IDLE, HOLD} state_t;
   state_t state_r, state_nx;
   logic [2:0] elig;
   logic [1:0] ptr_r, start, gidx, idx;
   logic [UID_W-1:0] a_uid [3], b_uid [3];
   logic [PRICE_W-1:0] a_pr [3], b_pr [3];
   logic [QTY_W-1:0] a_q [3], b_q [3];
   logic [QTY_W-1:0] s_aq, s_bq;
   logic load, acc;
   assign elig = {mk_bid_head_vld_r & mk_ask_head_vld_r & (MK_MK_EN != 0),
                  lm_ask_vld_r & mk_bid_head_vld_r,
                  lm_bid_vld_r & mk_ask_head_vld_r};
   assign start = ARB_MODE != 0 ? ptr_r : 2'd0;
   assign load = state_r == IDLE && trade_qry && |elig;
   assign acc = trade_vld_r & trade_rdy;
   assign trade_vld_r = state_r == HOLD;
   assign busy = trade_vld_r;
   assign s_aq = a_q[gidx];
   assign s_bq = b_q[gidx];
   // ask/bid side fields of each candidate pairing; MA/MB prices both sides at the ask price
   always_comb begin
      a_uid[0] = mk_ask_uid;   a_pr[0] = mk_ask_price; a_q[0] = mk_ask_qty;
      b_uid[0] = lm_bid_uid;   b_pr[0] = lm_bid_price; b_q[0] = lm_bid_qty;
      a_uid[1] = lm_ask_uid;   a_pr[1] = lm_ask_price; a_q[1] = lm_ask_qty;
      b_uid[1] = mk_bid_uid;   b_pr[1] = mk_bid_price; b_q[1] = mk_bid_qty;
      a_uid[2] = mk_ask_uid;   a_pr[2] = mk_ask_price; a_q[2] = mk_ask_qty;
      b_uid[2] = mk_bid_uid;   b_pr[2] = mk_ask_price; b_q[2] = mk_bid_qty;
   end
   // grant the first eligible candidate at or after the start index, wrapping modulo 3
   always_comb begin
      gidx = 2'd0;
      idx = 2'd0;
      for (int i = 2; i >= 0; i--) begin
         idx = 2'((int'(start) + i) % 3);
         if (elig[idx]) gidx = idx;
      end
   end
   // IDLE latches a trade on a qualified query; HOLD waits for acceptance
   always_comb begin
      state_nx = state_r == IDLE ? (load ? HOLD : IDLE) : (acc ? IDLE : HOLD);
   end
   // state, round-robin pointer and saturating accept counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         ptr_r <= 2'd0;
         trade_cnt_r <= '0;
      end else begin
         state_r <= state_nx;
         if (acc) begin
            trade_cnt_r <= &trade_cnt_r ? trade_cnt_r : trade_cnt_r + 1'b1;
            ptr_r <= ARB_MODE == 0 ? 2'd0 : trade_kind_r[0] ? 2'd1 : trade_kind_r[1] ? 2'd2 : 2'd0;
         end
      end
   end
   // enable-only trade register: loaded on a granted query, otherwise holds its value
   always_ff @(posedge clk) begin
      if (rst) begin
         trade_kind_r <= '0;
         trade_ask_uid_r <= '0;
         trade_bid_uid_r <= '0;
         trade_ask_price_r <= '0;
         trade_bid_price_r <= '0;
         trade_ask_consumed_r <= 1'b0;
         trade_bid_consumed_r <= 1'b0;
         trade_quantity_r <= '0;
         trade_remainder_r <= '0;
      end else if (load) begin
         trade_kind_r <= 3'b001 << gidx;
         trade_ask_uid_r <= a_uid[gidx];
         trade_bid_uid_r <= b_uid[gidx];
         trade_ask_price_r <= a_pr[gidx];
         trade_bid_price_r <= b_pr[gidx];
         trade_ask_consumed_r <= s_aq <= s_bq;
         trade_bid_consumed_r <= s_bq <= s_aq;
         trade_quantity_r <= s_aq < s_bq ? s_aq : s_bq;
         trade_remainder_r <= s_aq < s_bq ? s_bq - s_aq : s_aq - s_bq;
      end
   end
endmodule
